dlx_operand_fetch: RTL
======================

// Module: dlx_operand_fetch
// PURPOSE
//  Decode/operand-fetch stage of the multicycle DLX, between the instruction register and the ALU/execute stage.
//  - Decodes the DLX instruction fields and drives the register file read addresses.
//  - Latches both operands, the sign-extended immediate and the destination register.
//  - Presents the result to execute through a valid/ready handshake.
// PARAMETERS
//  DATA_W   32  register/operand width
//  ADDR_W   5   register address width (32 registers)
// PORTS
//  Clock      in   1       rising-edge clock
//  Reset      in   1       synchronous, active-high reset
//  InValid    in   1       instruction on Instr is valid
//  InReady    out  1       stage can accept an instruction
//  Instr      in   32      DLX instruction word
//  ReadAddr1  out  ADDR_W  register file read port 1 address (rs1)
//  ReadAddr2  out  ADDR_W  register file read port 2 address (rs2)
//  ReadData1  in   DATA_W  register file read data 1 (combinational)
//  ReadData2  in   DATA_W  register file read data 2 (combinational)
//  RegWrite   in   1       register file write strobe (snooped)
//  WriteAddr  in   ADDR_W  register file write address (snooped)
//  WriteData  in   DATA_W  register file write data (snooped)
//  OutValid   out  1       operand bundle valid to execute
//  OutReady   in   1       execute accepts the bundle
//  OpA        out  DATA_W  latched rs1 value
//  OpB        out  DATA_W  latched rs2 value
//  Imm        out  DATA_W  sign-extended immediate/offset
//  RdAddr     out  ADDR_W  destination register
//  Opcode     out  6       Instr[31:26], latched
//  Func       out  11      Instr[10:0], latched (R-type function)
// BEHAVIOUR
//  - Clock/reset: single clock domain, port Clock. Reset is synchronous and active-high, port Reset.
//  - Reset values: state=IDLE, InReady=1, OutValid=0; OpA, OpB, Imm, Opcode, Func = 0; RdAddr=0; ReadAddr1/2=0.
//  - Decode rules:
//    - rs1 = Instr[25:21]; rs2 = Instr[20:16].
//    - R-type (opcode 6'h00): RdAddr = Instr[15:11].
//    - JAL (6'h03): RdAddr = 31.
//    - All other opcodes: RdAddr = Instr[20:16].
//    - J/JAL (6'h02/6'h03): Imm = sign-extended Instr[25:0]; otherwise Imm = sign-extended Instr[15:0].
//  - FSM states: IDLE, READ, HOLD.
//    - IDLE: InReady=1. On InValid=1, capture Instr into an internal IR and go to READ.
//    - READ: InReady=0. ReadAddr1/2 are driven from the IR rs1/rs2 (registered, stable all cycle).
//      At the closing edge, latch OpA, OpB, Imm, RdAddr, Opcode and Func; go to HOLD.
//    - HOLD: OutValid=1 and outputs are held stable. OutReady=1 -> IDLE and OutValid drops next cycle.
//      OutReady=0 -> remain in HOLD indefinitely.
//  - Latency: instruction accepted at edge N -> OutValid=1 in cycle after edge N+1. Throughput is at most 1 instruction per 3 cycles.
//  - ReadAddr1/2 hold their last value outside READ.
//  - Register 0: if rs1 or rs2 == 0, the corresponding operand is latched as 0 regardless of ReadData or bypass.
//  - Back-to-back: InValid high while not in IDLE is ignored. The upstream stage holds Instr until InReady=1.
//  - Reset mid-operation (READ or HOLD) -> reset values next cycle; the in-flight instruction is dropped.
//  - Widths: sign extension is by replicating bit 15 (or bit 25) up to DATA_W. No arithmetic is performed.
// CONFIGURATION
//  OPFETCH_BYPASS_EN defined:
//  - In READ, if RegWrite=1 and WriteAddr==rs1 (rs1!=0), OpA latches WriteData instead of ReadData1.
//  - Same rule for OpB against rs2.
//  - A simultaneous write matching both rs1 and rs2 bypasses both operands.
//  OPFETCH_BYPASS_EN undefined:
//  - OpA/OpB always latch ReadData1/ReadData2.
//  - A same-cycle write yields the pre-write value.
//  - The write snoop ports are unused.
// TESTING
//  Environment: bench pairs the block with RegisterFile (power-up contents reg i = i, i=1..30).
//  1. Reset: assert Reset 2 cycles -> InReady=1, OutValid=0, OpA=OpB=Imm=0.
//  2. R-type ADD r3,r5,r7 (Instr=32'h00A7_1820) -> OutValid 2 cycles after accept; OpA=5, OpB=7, RdAddr=3, Func=11'h020.
//  3. I-type imm=16'hFFFC, rs1=4 -> OpA=4, Imm=32'hFFFF_FFFC, RdAddr=Instr[20:16].
//  4. JAL offset 26'h3FF_FFF0 -> RdAddr=31, Imm=32'hFFFF_FFF0.
//     Hold OutReady=0 for 5 cycles -> outputs stable; OutReady=1 -> IDLE next cycle.
//  5. rs1=6, RegWrite=1, WriteAddr=6, WriteData=32'hDEAD_BEEF during READ:
//     - with OPFETCH_BYPASS_EN -> OpA=32'hDEAD_BEEF.
//     - without OPFETCH_BYPASS_EN -> OpA=6.
//  6. Reset asserted in READ, then in HOLD -> OutValid=0, state IDLE next cycle.
//     rs1=0 with WriteAddr=0 write -> OpA=0.

Source files
------------

// File: rtl/dlx_operand_fetch.sv
// DLX decode/operand-fetch stage: IDLE accepts an instruction, READ fetches operands, HOLD presents the bundle.
// Optional OPFETCH_BYPASS_EN forwards a same-cycle register write into the latched operands.
module dlx_operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       Instr,
  output logic [ADDR_W-1:0] ReadAddr1,
  output logic [ADDR_W-1:0] ReadAddr2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OpA,
  output logic [DATA_W-1:0] OpB,
  output logic [DATA_W-1:0] Imm,
  output logic [ADDR_W-1:0] RdAddr,
  output logic [5:0]        Opcode,
  output logic [10:0]       Func
);

  typedef enum logic [1:0] {IDLE, READ, HOLD} stateType;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  stateType          state;
  stateType          nextState;
  logic [31:0]       ir;
  logic [5:0]        irOpcode;
  logic [DATA_W-1:0] fetchA;
  logic [DATA_W-1:0] fetchB;
  logic [DATA_W-1:0] decodedImm;
  logic [ADDR_W-1:0] decodedRd;

  assign irOpcode = ir[31:26];

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    InReady   = 1'b0;
    OutValid  = 1'b0;
    case (state)
      IDLE: begin
        InReady = 1'b1;
        if (InValid) nextState = READ;
      end
      READ: nextState = HOLD;
      HOLD: begin
        OutValid = 1'b1;
        if (OutReady) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Jumps carry a 26-bit offset; everything else a 16-bit immediate.
  always_comb begin
    decodedImm = {{(DATA_W-16){ir[15]}}, ir[15:0]};
    decodedRd  = ADDR_W'(ir[20:16]);
    if (irOpcode == OP_J || irOpcode == OP_JAL)
      decodedImm = {{(DATA_W-26){ir[25]}}, ir[25:0]};
    if (irOpcode == OP_RTYPE)
      decodedRd = ADDR_W'(ir[15:11]);
    else if (irOpcode == OP_JAL)
      decodedRd = ADDR_W'(5'd31);
  end

`ifdef OPFETCH_BYPASS_EN
  assign fetchA = (RegWrite && WriteAddr == ReadAddr1) ? WriteData : ReadData1;
  assign fetchB = (RegWrite && WriteAddr == ReadAddr2) ? WriteData : ReadData2;
`else
  logic unusedSnoop;
  assign unusedSnoop = ^{RegWrite, WriteAddr, WriteData};
  assign fetchA = ReadData1;
  assign fetchB = ReadData2;
`endif

  // Read addresses are registered at accept so they are stable for the whole READ cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ir        <= '0;
      ReadAddr1 <= '0;
      ReadAddr2 <= '0;
      OpA       <= '0;
      OpB       <= '0;
      Imm       <= '0;
      RdAddr    <= '0;
      Opcode    <= '0;
      Func      <= '0;
    end else begin
      if (state == IDLE && InValid) begin
        ir        <= Instr;
        ReadAddr1 <= ADDR_W'(Instr[25:21]);
        ReadAddr2 <= ADDR_W'(Instr[20:16]);
      end
      if (state == READ) begin
        OpA    <= (ReadAddr1 == '0) ? '0 : fetchA;
        OpB    <= (ReadAddr2 == '0) ? '0 : fetchB;
        Imm    <= decodedImm;
        RdAddr <= decodedRd;
        Opcode <= irOpcode;
        Func   <= ir[10:0];
      end
    end
  end

endmodule
